// File: rtl/modseg_pkg.sv
// Shared types for the segment-unit scheduler: FSM state encoding, default width, index-width helper.
// Pure declarations; no logic, no latency, no flow control.
package modseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 32;

  // Index width for n items, never below one bit so single-entry configs still elaborate.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/modseg_rr_arbiter.sv
// Combinational round-robin picker: first set req bit searching upward from rr_ptr, with wrap.
// Zero latency; no backpressure, the caller decides when to sample the pick.
module modseg_rr_arbiter
  import modseg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // rr_ptr never exceeds NUM_REQ-1, so a single subtraction handles the wrap.
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = ID_W'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modseg_sched.sv
// Round-robin scheduler for one shared segment unit; req-to-valid is 2+L cycles, one transaction in flight,
// later requesters simply wait with req held. Optional WAIT watchdog enabled by SEG_SCHED_TIMEOUT_EN.
module modseg_sched
  import modseg_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 16,
  localparam int ID_W       = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      unit_start,
  output logic [DATA_W-1:0]         unit_operand,
  input  logic                      unit_valid,
  input  logic [DATA_W-1:0]         unit_result,
  output logic                      valid,
  output logic [DATA_W-1:0]         result,
  output logic [ID_W-1:0]           result_id,
  output logic                      busy,
  output logic                      timeout_err
);

  // Illegal configurations refer to a module that does not exist, so elaboration stops.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    modseg_sched_illegal_num_req u_bad ();
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    modseg_sched_illegal_timeout_cyc u_bad ();
  end

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;

`ifdef SEG_SCHED_TIMEOUT_EN
  localparam int CNT_W = id_w(TIMEOUT_CYC);
  logic [CNT_W-1:0] wait_cnt;
`endif

  modseg_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      unit_start   <= 1'b0;
      unit_operand <= '0;
      valid        <= 1'b0;
      result       <= '0;
      result_id    <= '0;
      rr_ptr       <= '0;
`ifdef SEG_SCHED_TIMEOUT_EN
      timeout_err  <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant        <= arb_gnt;
            unit_operand <= req_data[arb_idx*DATA_W +: DATA_W];
            result_id    <= arb_idx;
            unit_start   <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          unit_start <= 1'b0;
`ifdef SEG_SCHED_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
          state      <= WAIT;
        end
        WAIT: begin
          if (unit_valid) begin
            result <= unit_result;
            valid  <= 1'b1;
            grant  <= '0;
            state  <= DONE;
          end
`ifdef SEG_SCHED_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            result      <= '0;
            valid       <= 1'b1;
            timeout_err <= 1'b1;
            grant       <= '0;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          valid  <= 1'b0;
`ifdef SEG_SCHED_TIMEOUT_EN
          timeout_err <= 1'b0;
`endif
          rr_ptr <= (int'(result_id) == NUM_REQ - 1) ? '0 : result_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SEG_SCHED_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/modseg_sched.md
# modseg_sched

Round-robin scheduler sharing one segment-calculation unit (the `delay`-based if/else segment datapath of the modulation pipe) between up to NUM_REQ requesters. Latches the winning requester's 32-bit operand and issues it to the unit with a one-cycle start pulse. Waits for the unit's result, then returns it with a valid pulse tagged by requester index. Sits between the modulation-pipe branch stages and the single shared segment unit, replacing per-branch unit copies.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width
- TIMEOUT_CYC, 16, WAIT-state watchdog limit in cycles (used only with SEG_SCHED_TIMEOUT_EN)
- ID_W, derived, clog2(NUM_REQ)

Ports (clock and reset first; one clock `clk`; reset `reset` is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NUM_REQ  per-requester request; held high until that requester sees valid with its id
- req_data  in  NUM_REQ*DATA_W  operand of requester i in slice [i*DATA_W +: DATA_W]
- grant  out  NUM_REQ  one-hot, served requester, high in ISSUE and WAIT
- unit_start  out  1  one-cycle start pulse to shared unit
- unit_operand  out  DATA_W  latched operand, stable ISSUE through DONE
- unit_valid  in  1  shared unit result ready
- unit_result  in  DATA_W  shared unit result
- valid  out  1  one-cycle result pulse
- result  out  DATA_W  captured result, held until next capture
- result_id  out  ID_W  index of requester owning result
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  pulses with valid on watchdog abort; tied 0 without macro

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req bit high, pick first set bit searching upward from rr_ptr with wrap; latch req_data slice into unit_operand, index into result_id; go ISSUE. No req: stay.
- ISSUE: unit_start=1 for exactly this cycle; go WAIT. unit_valid is ignored in ISSUE.
- WAIT: on unit_valid, register unit_result into result; go DONE.
- DONE: valid=1 for one cycle; rr_ptr <= (result_id+1) mod NUM_REQ; go IDLE.
- A request is latched at grant: deasserting req during ISSUE/WAIT does not cancel; the transaction completes and valid still pulses.
- req changes outside IDLE are ignored; arbitration is sampled only in IDLE.
- Only one transaction is outstanding; unit_valid in IDLE or DONE is ignored.
- Reset values: grant 0, unit_start 0, unit_operand 0, valid 0, result 0, result_id 0, busy 0, timeout_err 0, rr_ptr 0, state IDLE.
- Reset mid-operation aborts the transaction with no valid; the shared unit shares this reset.

## Timing
- Unit latency L >= 1 cycles (L=1 for the delay-register unit).
- req seen in IDLE at cycle 0: unit_start at cycle 1; unit_valid at cycle 1+L; valid at cycle 2+L.
- With L=1: req-to-valid 3 cycles; back-to-back grants every 4 cycles.
- A requester drops req on the edge after its valid, so it is low in the following IDLE.

## Configuration
- SEG_SCHED_TIMEOUT_EN defined: a WAIT counter starts at 0 on WAIT entry. If it reaches TIMEOUT_CYC-1 with no unit_valid, go to DONE with result=0, valid=1 and timeout_err=1. rr_ptr advances normally.
- Not defined: no counter; WAIT holds indefinitely; timeout_err constant 0.

## Structure
- Shared package modseg_pkg: state enum (IDLE/ISSUE/WAIT/DONE), default DATA_W, ID_W helper function.
- One sub-module: modseg_rr_arbiter, a combinational round-robin picker. Inputs req and rr_ptr; outputs one-hot grant, index and any flag.
- Top contains the FSM, operand/result registers, rr_ptr and the optional watchdog.

## Test plan
- Single request: req=4'b0100, slice2=0x0000_00AB, echo unit L=1 -> grant=0100 cycles 1-2, unit_start cycle 1, valid cycle 3, result=0xAB, result_id=2.
- All four requests after reset, operands 0x10..0x13 -> service order 0,1,2,3, valid 4 cycles apart, results 0x10..0x13.
- Fairness: req0 and req3 re-asserted continuously -> grants alternate 0,3,0,3; no back-to-back repeat.
- Requester drops req during WAIT -> transaction completes; valid and result still delivered with its id.
- Reset asserted in WAIT -> busy, grant, unit_start, valid all 0 immediately. After release, first grant goes to lowest set req (rr_ptr=0).
- Macro on, TIMEOUT_CYC=16, unit never responds -> valid=1, timeout_err=1, result=0 on the DONE cycle after the counter hits 15. Macro off -> busy stays 1 with no valid.
